// File: rtl/astro_pkg.sv
// Shared types and defaults for the NCC frame server: geometry defaults,
// pixel/coordinate types, FSM state and read-source encodings.
package astro_pkg;

  localparam int IMG_DIM_DEF = 128;
  localparam int TEM_DIM_DEF = 32;
  localparam int PIX_W_DEF   = 8;
  localparam int COORD_W     = 7;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef logic [COORD_W-1:0]   coord_t;

  typedef enum logic [1:0] {LOAD, READY, DONE} fs_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_TEM, SRC_WIN} rd_src_t;

  function automatic logic in_square(input coord_t r, input coord_t c, input int dim);
    return (int'(r) < dim) && (int'(c) < dim);
  endfunction

endpackage

// File: rtl/ncc_frame_server_if.sv
// Host-load and engine-access bus of the NCC frame server.
// Carries frame_cksum only when FRAME_CHECKSUM_EN is defined.
interface ncc_frame_server_if
  import astro_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) ();

  logic             host_wr_en;
  logic             host_tem_win;
  coord_t           host_row;
  coord_t           host_col;
  logic [PIX_W-1:0] host_pixel;
  logic             host_frame_done;
  logic             host_ack;

  logic             req;
  logic             rd_wr;
  logic [31:0]      write_data;
  coord_t           row;
  coord_t           col;
  logic             tem_win;
  logic             set_done;

  logic [31:0]      read_data;
  logic             ready_2_start;
  logic             frame_busy;
  logic             addr_err;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0]      frame_cksum;
`endif

  modport master (
    output host_wr_en, host_tem_win, host_row, host_col, host_pixel, host_frame_done, host_ack,
    output req, rd_wr, write_data, row, col, tem_win, set_done,
`ifdef FRAME_CHECKSUM_EN
    input  frame_cksum,
`endif
    input  read_data, ready_2_start, frame_busy, addr_err
  );

  modport slave (
    input  host_wr_en, host_tem_win, host_row, host_col, host_pixel, host_frame_done, host_ack,
    input  req, rd_wr, write_data, row, col, tem_win, set_done,
`ifdef FRAME_CHECKSUM_EN
    output frame_cksum,
`endif
    output read_data, ready_2_start, frame_busy, addr_err
  );

endinterface

// File: rtl/ncc_pixel_ram.sv
// Single-port synchronous pixel RAM, one-cycle read latency, write-first.
// The output register only moves when en is high, so it holds between reads.
module ncc_pixel_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (en) q <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/ncc_frame_server.sv
// Frame memory in front of the NCC engine: host loads in LOAD, engine accesses in READY,
// DONE waits for host_ack. Optional frame_cksum under FRAME_CHECKSUM_EN.
module ncc_frame_server
  import astro_pkg::*;
#(
  parameter int IMG_DIM = IMG_DIM_DEF,
  parameter int TEM_DIM = TEM_DIM_DEF,
  parameter int PIX_W   = PIX_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  ncc_frame_server_if.slave bus
);

  localparam int TA_W = $clog2(TEM_DIM * TEM_DIM);
  localparam int WA_W = $clog2(IMG_DIM * IMG_DIM);

  fs_state_t        state;
  rd_src_t          rd_src;
  logic             ready_q, busy_q, err_q;
  coord_t           sel_row, sel_col;
  logic             sel_tem, in_range, host_ok, eng_ok, wr_ok, rd_ok, err_set, leave_done;
  logic [PIX_W-1:0] wdata, tem_q, win_q;
  logic [TA_W-1:0]  tem_addr;
  logic [WA_W-1:0]  win_addr;
  logic             unused_wdata_hi;

  assign unused_wdata_hi = ^bus.write_data[31:PIX_W];

  // The host owns the RAM port in LOAD, the engine everywhere else.
  always_comb begin
    sel_tem = bus.tem_win;
    sel_row = bus.row;
    sel_col = bus.col;
    if (state == LOAD) begin
      sel_tem = bus.host_tem_win;
      sel_row = bus.host_row;
      sel_col = bus.host_col;
    end
  end

  assign in_range   = sel_tem ? in_square(sel_row, sel_col, TEM_DIM)
                              : in_square(sel_row, sel_col, IMG_DIM);
  assign host_ok    = bus.host_wr_en && (state == LOAD);
  assign eng_ok     = bus.req && (state == READY);
  assign wr_ok      = (host_ok || (eng_ok && bus.rd_wr)) && in_range;
  assign rd_ok      = eng_ok && !bus.rd_wr && in_range;
  assign err_set    = (bus.host_wr_en && (state != LOAD)) || (bus.req && (state != READY)) ||
                      ((host_ok || eng_ok) && !in_range);
  assign leave_done = (state == DONE) && bus.host_ack;
  assign wdata      = host_ok ? bus.host_pixel : bus.write_data[PIX_W-1:0];
  assign tem_addr   = TA_W'(sel_row) * TA_W'(TEM_DIM) + TA_W'(sel_col);
  assign win_addr   = WA_W'(sel_row) * WA_W'(IMG_DIM) + WA_W'(sel_col);

  ncc_pixel_ram #(.DEPTH(TEM_DIM * TEM_DIM), .WIDTH(PIX_W)) u_tem_ram (
    .clk   (clk),
    .en    (rd_ok && sel_tem),
    .we    (wr_ok && sel_tem),
    .addr  (tem_addr),
    .wdata (wdata),
    .q     (tem_q)
  );

  ncc_pixel_ram #(.DEPTH(IMG_DIM * IMG_DIM), .WIDTH(PIX_W)) u_win_ram (
    .clk   (clk),
    .en    (rd_ok && !sel_tem),
    .we    (wr_ok && !sel_tem),
    .addr  (win_addr),
    .wdata (wdata),
    .q     (win_q)
  );

  // rd_src remembers what the last read hit, so read_data holds across writes.
  always_comb begin
    case (rd_src)
      SRC_TEM: bus.read_data = 32'(tem_q);
      SRC_WIN: bus.read_data = 32'(win_q);
      default: bus.read_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      rd_src  <= SRC_NONE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (eng_ok && !bus.rd_wr)
        rd_src <= !in_range ? SRC_NONE : (bus.tem_win ? SRC_TEM : SRC_WIN);
      if (leave_done)   err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
      case (state)
        LOAD: if (bus.host_frame_done) begin
          state   <= READY;
          ready_q <= 1'b1;
        end
        READY: if (bus.set_done) begin
          state   <= DONE;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        DONE: if (bus.host_ack) begin
          state  <= LOAD;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= LOAD;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_2_start = ready_q;
  assign bus.frame_busy    = busy_q;
  assign bus.addr_err      = err_q;

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] cksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       cksum_q <= '0;
    else if (leave_done)                              cksum_q <= '0;
    else if (host_ok && !bus.host_tem_win && in_range) cksum_q <= cksum_q + 16'(bus.host_pixel);
  end

  assign bus.frame_cksum = cksum_q;
`endif

endmodule

// File: tb/tb_ncc_frame_server.sv
// Self-checking bench for ncc_frame_server: directed vector table, randomized
// engine traffic against a frame-memory model, and handshake/reset sequences.
module tb_ncc_frame_server;
  import astro_pkg::*;

  localparam int IMG = 128;
  localparam int TEM = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ncc_frame_server_if #(.PIX_W(8)) bus ();

  ncc_frame_server #(.IMG_DIM(IMG), .TEM_DIM(TEM), .PIX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: pixel arrays, phase (0 load, 1 ready, 2 done), sticky error, last read, checksum.
  logic [7:0]  win_m [IMG*IMG];
  logic [7:0]  tem_m [TEM*TEM];
  int          ph;
  logic        err_m;
  logic [31:0] last_rd;
  logic [15:0] cksum_m;

  typedef struct {
    logic        rw;
    logic        tw;
    int          r;
    int          c;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.host_wr_en = 0; bus.host_tem_win = 0; bus.host_row = '0; bus.host_col = '0;
    bus.host_pixel = '0; bus.host_frame_done = 0; bus.host_ack = 0;
    bus.req = 0; bus.rd_wr = 0; bus.write_data = '0; bus.row = '0; bus.col = '0;
    bus.tem_win = 0; bus.set_done = 0;
  endtask

  function automatic logic inRange(input logic tw, input int r, input int c);
    return tw ? (r < TEM && c < TEM) : (r < IMG && c < IMG);
  endfunction

  task automatic hostWrite(input logic tw, input int r, input int c, input logic [7:0] p,
                           input logic fd);
    bus.host_wr_en = 1; bus.host_tem_win = tw; bus.host_row = 7'(r); bus.host_col = 7'(c);
    bus.host_pixel = p; bus.host_frame_done = fd;
    tick();
    bus.host_wr_en = 0; bus.host_frame_done = 0;
    if (ph != 0 || !inRange(tw, r, c)) err_m = 1;
    else if (tw) tem_m[r*TEM+c] = p;
    else begin
      win_m[r*IMG+c] = p;
      cksum_m = cksum_m + 16'(p);
    end
    if (fd && ph == 0) ph = 1;
  endtask

  task automatic applyStimulus(input logic rw, input logic tw, input int r, input int c,
                               input logic [31:0] wd, input logic sd);
    bus.req = 1; bus.rd_wr = rw; bus.tem_win = tw; bus.row = 7'(r); bus.col = 7'(c);
    bus.write_data = wd; bus.set_done = sd;
    tick();
    bus.req = 0; bus.set_done = 0;
    if (ph != 1) err_m = 1;
    else if (!inRange(tw, r, c)) begin
      err_m = 1;
      if (!rw) last_rd = 0;
    end else if (rw) begin
      if (tw) tem_m[r*TEM+c] = wd[7:0];
      else    win_m[r*IMG+c] = wd[7:0];
    end else begin
      last_rd = tw ? 32'(tem_m[r*TEM+c]) : 32'(win_m[r*IMG+c]);
    end
    if (sd && ph == 1) ph = 2;
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, ".ready"}, 32'(bus.ready_2_start), 32'(ph == 1));
    checkOutput({tag, ".busy"},  32'(bus.frame_busy),    32'(ph == 2));
    checkOutput({tag, ".err"},   32'(bus.addr_err),      32'(err_m));
  endtask

  initial begin
    int r, c, pr, pc;
    logic rw, tw, ptw;

    idleInputs();
    rst_n = 0;
    ph = 0; err_m = 0; last_rd = 0; cksum_m = 0;
    #12;
    checkOutput("reset.read_data", bus.read_data, 32'h0);
    checkStatus("reset");
`ifdef FRAME_CHECKSUM_EN
    checkOutput("reset.cksum", 32'(bus.frame_cksum), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1;
    tick();

    // Frame 1 load; frame_done rides on the last template write.
    for (int i = 0; i < IMG; i++)
      for (int j = 0; j < IMG; j++)
        hostWrite(1'b0, i, j, 8'((i * j) % 256), 1'b0);
    checkStatus("load.mid");
    for (int i = 0; i < TEM; i++)
      for (int j = 0; j < TEM; j++)
        hostWrite(1'b1, i, j, 8'((i + j) % 256), (i == TEM - 1) && (j == TEM - 1));
    checkOutput("load.ready_rise", 32'(bus.ready_2_start), 32'h1);
    checkStatus("load.done");
`ifdef FRAME_CHECKSUM_EN
    checkOutput("f1.cksum", 32'(bus.frame_cksum), 32'(cksum_m));
`endif

    vecs[0]  = '{1'b0, 1'b0,  3,  5, 32'h0,    32'd15,       1'b0};
    vecs[1]  = '{1'b0, 1'b1, 31, 31, 32'h0,    32'd62,       1'b0};
    vecs[2]  = '{1'b1, 1'b0, 10, 10, 32'h1AB,  32'd62,       1'b0};
    vecs[3]  = '{1'b0, 1'b0, 10, 10, 32'h0,    32'h000000AB, 1'b0};
    vecs[4]  = '{1'b1, 1'b1,  0,  0, 32'h5A5A, 32'h000000AB, 1'b0};
    vecs[5]  = '{1'b0, 1'b1,  0,  0, 32'h0,    32'h0000005A, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 40,  0, 32'h0,    32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b1, 40,  0, 32'h33,   32'h0,        1'b1};
    vecs[8]  = '{1'b0, 1'b1,  8,  0, 32'h0,    32'd8,        1'b1};
    vecs[9]  = '{1'b0, 1'b1,  5, 33, 32'h0,    32'h0,        1'b1};
    vecs[10] = '{1'b0, 1'b0,  3,  5, 32'h0,    32'd15,       1'b1};

    for (int i = 0; i < $size(vecs); i++) begin
      applyStimulus(vecs[i].rw, vecs[i].tw, vecs[i].r, vecs[i].c, vecs[i].wd, 1'b0);
      checkOutput($sformatf("vec%0d.read_data", i), bus.read_data, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d.addr_err", i), 32'(bus.addr_err), 32'(vecs[i].exp_err));
    end

    // Random engine traffic, with some same-address reuse and stray template coordinates.
    pr = 0; pc = 0; ptw = 0;
    for (int i = 0; i < 300; i++) begin
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        tw = ptw; r = pr; c = pc;
      end else begin
        tw = 1'($urandom_range(0, 1));
        r  = tw ? $urandom_range(0, TEM - 1) : $urandom_range(0, IMG - 1);
        c  = tw ? $urandom_range(0, TEM - 1) : $urandom_range(0, IMG - 1);
        if (tw && $urandom_range(0, 9) == 0) r = $urandom_range(TEM, IMG - 1);
      end
      applyStimulus(rw, tw, r, c, $urandom, 1'b0);
      checkOutput($sformatf("rnd%0d.read_data", i), bus.read_data, last_rd);
      checkOutput($sformatf("rnd%0d.addr_err", i), 32'(bus.addr_err), 32'(err_m));
      ptw = tw; pr = r; pc = c;
    end
`ifdef FRAME_CHECKSUM_EN
    checkOutput("f1.cksum_frozen", 32'(bus.frame_cksum), 32'(cksum_m));
`endif

    // set_done with a coincident read, then the host acknowledge.
    applyStimulus(1'b0, 1'b0, 2, 2, 32'h0, 1'b1);
    checkOutput("hs.read_data", bus.read_data, last_rd);
    checkStatus("hs.done");
    tick();
    checkStatus("hs.hold");
    bus.host_ack = 1;
    tick();
    bus.host_ack = 0;
    ph = 0; err_m = 0; cksum_m = 0;
    checkStatus("hs.load");
`ifdef FRAME_CHECKSUM_EN
    checkOutput("hs.cksum_clear", 32'(bus.frame_cksum), 32'h0);
`endif

    // Frame 2: illegal engine access in LOAD, short load, ignored ack and host write in READY.
    applyStimulus(1'b0, 1'b0, 1, 1, 32'h0, 1'b0);
    checkOutput("f2.drop_req.read_data", bus.read_data, last_rd);
    checkStatus("f2.drop_req");
    hostWrite(1'b0, 1, 1, 8'h99, 1'b0);
    hostWrite(1'b0, 1, 2, 8'h42, 1'b1);
    checkStatus("f2.ready");
    bus.host_ack = 1;
    tick();
    bus.host_ack = 0;
    checkStatus("f2.ack_ignored");
    hostWrite(1'b0, 1, 1, 8'h00, 1'b0);
    checkStatus("f2.drop_host");
`ifdef FRAME_CHECKSUM_EN
    checkOutput("f2.cksum", 32'(bus.frame_cksum), 32'(cksum_m));
`endif
    applyStimulus(1'b0, 1'b0, 1, 1, 32'h0, 1'b0);
    checkOutput("f2.rd11", bus.read_data, 32'h99);
    checkOutput("f2.rd11.model", bus.read_data, last_rd);

    // Asynchronous reset while a read is in flight.
    bus.req = 1; bus.rd_wr = 0; bus.tem_win = 0; bus.row = 7'd1; bus.col = 7'd2;
    @(posedge clk);
    #2;
    checkOutput("pre_rst.read_data", bus.read_data, 32'h42);
    #1;
    rst_n = 0;
    #1;
    idleInputs();
    ph = 0; err_m = 0; last_rd = 0; cksum_m = 0;
    checkOutput("rst.read_data", bus.read_data, 32'h0);
    checkStatus("rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    hostWrite(1'b0, 0, 0, 8'h77, 1'b1);
    checkStatus("post_rst.ready");
`ifdef FRAME_CHECKSUM_EN
    checkOutput("post_rst.cksum", 32'(bus.frame_cksum), 32'h77);
`endif
    applyStimulus(1'b0, 1'b0, 0, 0, 32'h0, 1'b0);
    checkOutput("post_rst.rd00", bus.read_data, 32'h77);
    checkStatus("post_rst.read");

`ifdef FRAME_CHECKSUM_EN
    // Full window of 8'hFF: 16384 * 255 mod 2^16.
    applyStimulus(1'b0, 1'b0, 0, 0, 32'h0, 1'b1);
    bus.host_ack = 1;
    tick();
    bus.host_ack = 0;
    ph = 0; err_m = 0; cksum_m = 0;
    for (int i = 0; i < IMG; i++)
      for (int j = 0; j < IMG; j++)
        hostWrite(1'b0, i, j, 8'hFF, (i == IMG - 1) && (j == IMG - 1));
    checkOutput("ff.cksum", 32'(bus.frame_cksum), 32'h0000C000);
    applyStimulus(1'b1, 1'b0, 0, 0, 32'h12, 1'b0);
    checkOutput("ff.cksum_after_wr", 32'(bus.frame_cksum), 32'h0000C000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
